fifo_multi_pop: RTL and testbench
=================================

Name: fifo_multi_pop

Overview:
Banked FIFO with one push port and four in-order pop ports. It pops up to four entries per cycle. Storage is four banks of N entries. A one-hot push index rotates by 1 on every accepted push. A one-hot pop index rotates by the number of pops granted. It sits downstream of a single producer and feeds a 4-wide consumer, such as a decode/issue stage that retires a variable number of entries each cycle.

Parameters:
W, 32, data width in bits
N, 8, entries per bank; must be a power of 2 and ≥2; total capacity 4*N

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  reset, asynchronous, active-high
push  input  1  push request
push_data  input  W  push payload
pop_0  input  1  pop request, oldest slot
pop_1  input  1  pop request, 2nd-oldest slot
pop_2  input  1  pop request, 3rd-oldest slot
pop_3  input  1  pop request, 4th-oldest slot
pop_0_valid_r  output  1  slot 0 granted last cycle
pop_0_data_r  output  W  slot 0 data
pop_1_valid_r / pop_1_data_r  output  1 / W  same, slot 1
pop_2_valid_r / pop_2_data_r  output  1 / W  same, slot 2
pop_3_valid_r / pop_3_data_r  output  1 / W  same, slot 3
empty_r  output  1  occupancy == 0
full_r  output  1  occupancy == 4*N
avail_r  output  3  min(occupancy, 4): number of pops legal next cycle
err_r  output  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset (asynchronous, active-high, clk/rst):
  - all bank rd/wr pointers = 0; push_idx and pop_idx = 4'b0001; occupancy cnt_r = 0
  - empty_r=1, full_r=0, avail_r=0, all pop_i_valid_r=0, err_r=0
  - pop_i_data_r not reset; check only when the matching valid is 1
  - reset mid-operation discards all contents; the first cycle after release behaves exactly like the post-reset state
- Per-bank pointers are $clog2(N)+1 bits: index plus wrap bit. Increment wraps naturally.
- Push:
  - accepted iff push & ~full_r
  - write goes to bank push_idx at that bank's wr ptr; that wr ptr increments; push_idx rotates left by 1
  - push while full_r=1 is dropped; no state change
- Pop grant:
  - g[i] = pop_i & pop_0..pop_{i-1} all asserted & (i < avail_r)
  - requests that are non-prefix (e.g. pop_1 without pop_0) or exceed avail_r are ignored; lower prefix pops are still granted
  - npop = popcount(g), 0..4
  - slot i reads bank rotl(pop_idx, i) at that bank's rd ptr; each granted bank's rd ptr increments
  - pop_idx rotates left by npop
- Latency: 1 cycle. pop_i_valid_r <= g[i]; pop_i_data_r <= read data for slot i, loaded only when g[i]=1.
- No bypass: data pushed in cycle t is poppable from cycle t+1 (reflected in avail_r at t+1).
- Status:
  - cnt_next = cnt_r + push_acc - npop, width $clog2(4*N)+1
  - empty_r, full_r, avail_r registered from cnt_next, so they reflect the state after the current cycle's operations
- Simultaneous push and pop when full_r=1: push is rejected (full_r is the registered pre-pop view); pop proceeds.
- Ordering: entries pop in exact push order, across bank and pointer wrap-around.

Optional Feature:
Macro FIFO_MULTI_POP_ERR_EN.
- Defined: err_r sets sticky, 1 cycle after any of:
  - push & full_r
  - non-prefix pop vector
  - any pop_i with i ≥ avail_r
  err_r clears only on rst. A simulation-only assertion also fires on the same condition.
- Undefined: err_r tied to 0; illegal requests are silently dropped/ignored as described above; no assertion.

Test Plan:
- Reset: assert rst async mid-cycle -> outputs immediately empty_r=1, full_r=0, avail_r=0, all valids 0, err_r=0.
- Push 5 entries 0xA0..0xA4; then pop_0..3=1 -> next cycle valids 4'b1111 with data A0,A1,A2,A3; avail_r=1. Next cycle pop_0 -> A4; empty_r=1.
- Push 32 entries (N=8) -> full_r=1 after the 32nd. The 33rd push is dropped and err_r=1 (macro on). Pop all in 8 four-wide pops -> data matches push order.
- avail_r=2, pops {pop_0,pop_1,pop_3}=1, pop_2=0 -> only slots 0,1 valid; occupancy decreases by 2; err_r=1 (macro on) / 0 (off).
- Continuous push every cycle plus alternating 1- and 3-wide pops for 200 cycles (pointer wrap in every bank) -> scoreboard order matches, no loss; full_r/empty_r consistent with the reference count.
- Empty FIFO, push 0x55 and pop_0 in the same cycle -> no valid next cycle (no bypass), avail_r=1; pop next cycle -> 0x55.

Source files
------------

// File: rtl/fifo_multi_pop.sv
// Banked FIFO: one push port, four in-order pop ports, storage as four N-deep banks.
// Optional sticky protocol-error flag and assertion under `define FIFO_MULTI_POP_ERR_EN.
module fifo_multi_pop #(
    parameter int W = 32,
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop_0,
    input  logic         pop_1,
    input  logic         pop_2,
    input  logic         pop_3,
    output logic         pop_0_valid_r,
    output logic [W-1:0] pop_0_data_r,
    output logic         pop_1_valid_r,
    output logic [W-1:0] pop_1_data_r,
    output logic         pop_2_valid_r,
    output logic [W-1:0] pop_2_data_r,
    output logic         pop_3_valid_r,
    output logic [W-1:0] pop_3_data_r,
    output logic         empty_r,
    output logic         full_r,
    output logic [2:0]   avail_r,
    output logic         err_r
);
    // Handshake: push and pop_i are requests with no ready. A push is taken when full_r
    // is low; slot i is granted when pop_0..pop_i are all set and i < avail_r. Each grant
    // is echoed one cycle later as pop_i_valid_r with its data in pop_i_data_r.
    localparam int IW = $clog2(N);
    localparam int PW = IW + 1;
    localparam int AW = $clog2(4 * N);
    localparam int CW = AW + 1;

    function automatic logic [3:0] rotl(input logic [3:0] v, input logic [1:0] s);
        case (s)
            2'd0:    rotl = v;
            2'd1:    rotl = {v[2:0], v[3]};
            2'd2:    rotl = {v[1:0], v[3:2]};
            default: rotl = {v[0], v[3:1]};
        endcase
    endfunction

    function automatic logic [1:0] oh2idx(input logic [3:0] oh);
        oh2idx = {oh[3] | oh[2], oh[3] | oh[1]};
    endfunction

    logic [W-1:0]  mem [4*N];
    logic [PW-1:0] wr_ptr [4];
    logic [PW-1:0] rd_ptr [4];
    logic [3:0]    push_idx;
    logic [3:0]    pop_idx;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next;
    logic [3:0]    pop_req;
    logic [3:0]    pref;
    logic [3:0]    g;
    logic [3:0]    bank_empty;
    logic [3:0]    rd_inc;
    logic [1:0]    slot_bank [4];
    logic [W-1:0]  rdata [4];
    logic [1:0]    wb;
    logic [AW-1:0] waddr;
    logic          push_acc;
    logic [2:0]    npop;
    logic [3:0]    pv_r;
    logic [W-1:0]  pd_r [4];

    assign pop_req  = {pop_3, pop_2, pop_1, pop_0};
    assign push_acc = push & ~full_r;
    assign wb       = oh2idx(push_idx);
    assign waddr    = {wb, wr_ptr[wb][IW-1:0]};

    always_comb begin
        pref       = '0;
        g          = '0;
        rd_inc     = '0;
        bank_empty = '0;
        for (int b = 0; b < 4; b++) begin
            bank_empty[b] = (rd_ptr[b] == wr_ptr[b]);
        end
        for (int i = 0; i < 4; i++) begin
            pref[i]      = (i == 0) ? pop_req[0] : (pref[i-1] & pop_req[i]);
            slot_bank[i] = oh2idx(rotl(pop_idx, 2'(i)));
            rdata[i]     = mem[{slot_bank[i], rd_ptr[slot_bank[i]][IW-1:0]}];
            // The bank-empty term is redundant with avail_r; it guards against popping a dry bank.
            g[i] = pref[i] & (3'(i) < avail_r) & ~bank_empty[slot_bank[i]];
            if (g[i]) begin
                rd_inc[slot_bank[i]] = 1'b1;
            end
        end
        npop     = 3'(g[0]) + 3'(g[1]) + 3'(g[2]) + 3'(g[3]);
        cnt_next = cnt_r + CW'(push_acc) - CW'(npop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 4; b++) begin
                wr_ptr[b] <= '0;
                rd_ptr[b] <= '0;
            end
            push_idx <= 4'b0001;
            pop_idx  <= 4'b0001;
            cnt_r    <= '0;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            avail_r  <= 3'd0;
            pv_r     <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr[wb] <= wr_ptr[wb] + 1'b1;
                push_idx   <= rotl(push_idx, 2'd1);
            end
            for (int b = 0; b < 4; b++) begin
                if (rd_inc[b]) begin
                    rd_ptr[b] <= rd_ptr[b] + 1'b1;
                end
            end
            pop_idx <= rotl(pop_idx, npop[1:0]);
            cnt_r   <= cnt_next;
            empty_r <= (cnt_next == '0);
            full_r  <= (cnt_next == CW'(4 * N));
            avail_r <= (cnt_next >= CW'(4)) ? 3'd4 : cnt_next[2:0];
            pv_r    <= g;
        end
    end

    // Storage and read-data registers carry no reset; data is only meaningful under a valid.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[waddr] <= push_data;
        end
        for (int i = 0; i < 4; i++) begin
            if (g[i]) begin
                pd_r[i] <= rdata[i];
            end
        end
    end

    assign pop_0_valid_r = pv_r[0];
    assign pop_1_valid_r = pv_r[1];
    assign pop_2_valid_r = pv_r[2];
    assign pop_3_valid_r = pv_r[3];
    assign pop_0_data_r  = pd_r[0];
    assign pop_1_data_r  = pd_r[1];
    assign pop_2_data_r  = pd_r[2];
    assign pop_3_data_r  = pd_r[3];

`ifdef FIFO_MULTI_POP_ERR_EN
    logic [3:0] avail_mask;
    logic       err_cond;

    always_comb begin
        avail_mask = '0;
        for (int i = 0; i < 4; i++) begin
            avail_mask[i] = (3'(i) < avail_r);
        end
        err_cond = (push & full_r) | (|(pop_req & ~pref)) | (|(pop_req & ~avail_mask));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (err_cond) begin
            err_r <= 1'b1;
        end
    end

    assert property (@(posedge clk) disable iff (rst) !err_cond)
        else $error("fifo_multi_pop: illegal push/pop request");
`else
    assign err_r = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_multi_pop.sv
// Self-checking bench for fifo_multi_pop: table-driven vectors plus scoreboard-backed
// sequences for reset, fill/drain, pointer wrap and randomized traffic.
module tb_fifo_multi_pop;
    localparam int W   = 32;
    localparam int N   = 8;
    localparam int CAP = 4 * N;
`ifdef FIFO_MULTI_POP_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         push;
    logic [W-1:0] push_data;
    logic         pop_0, pop_1, pop_2, pop_3;
    logic         pop_0_valid_r, pop_1_valid_r, pop_2_valid_r, pop_3_valid_r;
    logic [W-1:0] pop_0_data_r, pop_1_data_r, pop_2_data_r, pop_3_data_r;
    logic         empty_r, full_r, err_r;
    logic [2:0]   avail_r;

    fifo_multi_pop #(.W(W), .N(N)) dut (
        .clk(clk), .rst(rst),
        .push(push), .push_data(push_data),
        .pop_0(pop_0), .pop_1(pop_1), .pop_2(pop_2), .pop_3(pop_3),
        .pop_0_valid_r(pop_0_valid_r), .pop_0_data_r(pop_0_data_r),
        .pop_1_valid_r(pop_1_valid_r), .pop_1_data_r(pop_1_data_r),
        .pop_2_valid_r(pop_2_valid_r), .pop_2_data_r(pop_2_data_r),
        .pop_3_valid_r(pop_3_valid_r), .pop_3_data_r(pop_3_data_r),
        .empty_r(empty_r), .full_r(full_r), .avail_r(avail_r), .err_r(err_r)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] model_q[$];
    logic         exp_err = 1'b0;
    logic [3:0]   exp_g = '0;

    typedef struct {
        logic         push;
        logic [W-1:0] data;
        logic [3:0]   pops;
        logic [3:0]   g;
        logic [2:0]   avail;
        logic         empty;
    } vec_t;
    vec_t vecs [15];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_out();
        logic [W-1:0] dd [4];
        logic [3:0]   vv;
        logic [W-1:0] e;
        int           sz;
        dd = '{pop_0_data_r, pop_1_data_r, pop_2_data_r, pop_3_data_r};
        vv = {pop_3_valid_r, pop_2_valid_r, pop_1_valid_r, pop_0_valid_r};
        chk("valid", 32'(vv), 32'(exp_g));
        for (int i = 0; i < 4; i++) begin
            if (exp_g[i]) begin
                e = exp_q.pop_front();
                if (vv[i]) chk($sformatf("data_%0d", i), dd[i], e);
            end
        end
        sz = model_q.size();
        chk("avail", 32'(avail_r), 32'((sz < 4) ? sz : 4));
        chk("empty", 32'(empty_r), 32'(sz == 0));
        chk("full",  32'(full_r),  32'(sz == CAP));
        chk("err",   32'(err_r),   32'(ERR_EN & exp_err));
    endtask

    // driver: apply one cycle of stimulus, update the reference queue, check after the edge
    task automatic cyc(input logic p, input logic [W-1:0] d, input logic [3:0] pops);
        int   cnt;
        int   av;
        logic pref_ok;
        logic illegal;
        push = p;
        push_data = d;
        {pop_3, pop_2, pop_1, pop_0} = pops;
        cnt = model_q.size();
        av = (cnt < 4) ? cnt : 4;
        exp_g = '0;
        pref_ok = 1'b1;
        illegal = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pref_ok = pref_ok & pops[i];
            if (pref_ok && i < av) begin
                exp_g[i] = 1'b1;
                exp_q.push_back(model_q.pop_front());
            end else if (pops[i]) begin
                illegal = 1'b1;
            end
        end
        if (p && cnt == CAP) illegal = 1'b1;
        else if (p) model_q.push_back(d);
        if (illegal) exp_err = 1'b1;
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        rst = 1'b1;
        push = 1'b0;
        push_data = '0;
        {pop_3, pop_2, pop_1, pop_0} = '0;

        vecs[0]  = '{1'b1, 32'hA0, 4'b0000, 4'b0000, 3'd1, 1'b0};
        vecs[1]  = '{1'b1, 32'hA1, 4'b0000, 4'b0000, 3'd2, 1'b0};
        vecs[2]  = '{1'b1, 32'hA2, 4'b0000, 4'b0000, 3'd3, 1'b0};
        vecs[3]  = '{1'b1, 32'hA3, 4'b0000, 4'b0000, 3'd4, 1'b0};
        vecs[4]  = '{1'b1, 32'hA4, 4'b0000, 4'b0000, 3'd4, 1'b0};
        vecs[5]  = '{1'b0, 32'h0,  4'b1111, 4'b1111, 3'd1, 1'b0};
        vecs[6]  = '{1'b0, 32'h0,  4'b0001, 4'b0001, 3'd0, 1'b1};
        vecs[7]  = '{1'b1, 32'h55, 4'b0001, 4'b0000, 3'd1, 1'b0};
        vecs[8]  = '{1'b0, 32'h0,  4'b0001, 4'b0001, 3'd0, 1'b1};
        vecs[9]  = '{1'b1, 32'hB0, 4'b0000, 4'b0000, 3'd1, 1'b0};
        vecs[10] = '{1'b1, 32'hB1, 4'b0000, 4'b0000, 3'd2, 1'b0};
        vecs[11] = '{1'b0, 32'h0,  4'b1011, 4'b0011, 3'd0, 1'b1};
        vecs[12] = '{1'b1, 32'hC0, 4'b0000, 4'b0000, 3'd1, 1'b0};
        vecs[13] = '{1'b0, 32'h0,  4'b0010, 4'b0000, 3'd1, 1'b0};
        vecs[14] = '{1'b0, 32'h0,  4'b0011, 4'b0001, 3'd0, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        check_out();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b0, '0, 4'b0000);

        // table-driven vectors
        for (int k = 0; k < 15; k++) begin
            cyc(vecs[k].push, vecs[k].data, vecs[k].pops);
            chk($sformatf("tbl%0d_g", k), 32'(exp_g), 32'(vecs[k].g));
            chk($sformatf("tbl%0d_avail", k), 32'(avail_r), 32'(vecs[k].avail));
            chk($sformatf("tbl%0d_empty", k), 32'(empty_r), 32'(vecs[k].empty));
        end

        // asynchronous reset mid-cycle while a pop result is being presented
        cyc(1'b1, 32'hD0, 4'b0000);
        cyc(1'b1, 32'hD1, 4'b0000);
        cyc(1'b0, '0, 4'b0011);
        push = 1'b0;
        {pop_3, pop_2, pop_1, pop_0} = '0;
        #3;
        rst = 1'b1;
        #1;
        model_q.delete();
        exp_q.delete();
        exp_err = 1'b0;
        exp_g = '0;
        check_out();
        chk("rst_avail", 32'(avail_r), 32'd0);
        #2;
        rst = 1'b0;
        cyc(1'b0, '0, 4'b0000);

        // fill to capacity, overflow push, push+pop while full, drain
        for (int k = 0; k < CAP; k++) cyc(1'b1, 32'h100 + 32'(k), 4'b0000);
        chk("full_after_fill", 32'(full_r), 32'd1);
        cyc(1'b1, 32'hDEAD, 4'b0000);
        cyc(1'b1, 32'hBEEF, 4'b0001);
        for (int k = 0; k < 12 && model_q.size() > 0; k++) cyc(1'b0, '0, 4'b1111);
        chk("empty_after_drain", 32'(empty_r), 32'd1);

        // continuous push with alternating 1- and 3-wide pops (wraps every bank)
        for (int k = 0; k < 200; k++) begin
            cyc(1'b1, $urandom, (k % 2 == 1) ? 4'b0111 : 4'b0001);
        end

        // randomized traffic including illegal request patterns
        for (int k = 0; k < 300; k++) begin
            cyc(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
        end
        for (int k = 0; k < 12 && model_q.size() > 0; k++) cyc(1'b0, '0, 4'b1111);
        cyc(1'b0, '0, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
